// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among NREQ
//               requesters; sends 1-4 byte messages LSB-first and paces bytes
//               with a frame-time counter. Optional strict priority for
//               requester 0 via macro UART_TX_ARB_PRIO0_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ         = 3,
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUDRATE     = 9600,
    parameter int FRAME_CYCLES = (CLK_FREQ / BAUDRATE + 2) * 12,
    parameter int ID_W         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [32*NREQ-1:0]     req_data,
    input  logic [2*NREQ-1:0]      req_len,
    output logic [NREQ-1:0]        req_ack,
    output logic                   tx_transmit,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);

    localparam int              c_cnt_w      = $clog2(FRAME_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(FRAME_CYCLES - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_pulse = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ID_W-1:0]     r_last;
    logic [31:0]         r_shreg;
    logic [1:0]          r_bytes;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [NREQ-1:0]     w_rr_valid;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic                w_upd_last;
    logic [31:0]         w_sel_data;
    logic [1:0]          w_sel_len;
    logic                w_frame_done;

    logic [NREQ-1:0]     w_ack_nxt;
    logic                w_transmit_nxt;
    logic                w_busy_nxt;

    function automatic int rr_index(input logic [ID_W-1:0] last, input int k);
        return (int'(last) + k) % NREQ;
    endfunction

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        w_rr_valid = req_valid;
        w_found    = 1'b0;
        w_winner   = '0;
        w_upd_last = 1'b0;
`ifdef UART_TX_ARB_PRIO0_EN
        w_rr_valid[0] = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && w_rr_valid[rr_index(r_last, k)]) begin
                w_found    = 1'b1;
                w_winner   = ID_W'(rr_index(r_last, k));
                w_upd_last = 1'b1;
            end
        end
`ifdef UART_TX_ARB_PRIO0_EN
        // Requester 0 overrides; the rotation pointer of the others is left alone.
        if (req_valid[0]) begin
            w_found    = 1'b1;
            w_winner   = '0;
            w_upd_last = 1'b0;
        end
`endif
        w_sel_data = req_data[32*int'(w_winner) +: 32];
        w_sel_len  = req_len[2*int'(w_winner) +: 2];
    end

    assign w_frame_done = (r_cnt == c_frame_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_found) w_state_nxt = c_st_load;
            c_st_load:  w_state_nxt = c_st_pulse;
            c_st_pulse: w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (w_frame_done) begin
                    w_state_nxt = (r_bytes != 2'd0) ? c_st_load : c_st_idle;
                end
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_ack_nxt      = '0;
        w_transmit_nxt = (r_state == c_st_pulse);
        w_busy_nxt     = busy;
        if (r_state == c_st_idle && w_found) begin
            w_ack_nxt  = NREQ'(1) << w_winner;
            w_busy_nxt = 1'b1;
        end
        if (r_state == c_st_wait && w_frame_done && r_bytes == 2'd0) begin
            w_busy_nxt = 1'b0;
        end
    end

    // tx_data is loaded one cycle ahead of the strobe so the UART sees it settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ack     <= '0;
            tx_transmit <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            r_last      <= ID_W'(NREQ - 1);
            r_shreg     <= '0;
            r_bytes     <= '0;
            r_cnt       <= '0;
        end else begin
            req_ack     <= w_ack_nxt;
            tx_transmit <= w_transmit_nxt;
            busy        <= w_busy_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_shreg  <= w_sel_data;
                        r_bytes  <= w_sel_len;
                        grant_id <= w_winner;
                        if (w_upd_last) r_last <= w_winner;
                    end
                end
                c_st_load:  tx_data <= r_shreg[7:0];
                c_st_pulse: r_cnt   <= '0;
                c_st_wait: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_frame_done && r_bytes != 2'd0) begin
                        r_shreg <= {8'd0, r_shreg[31:8]};
                        r_bytes <= r_bytes - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
